// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - CPU/debug arbiter and byte-lane mapper for the data memory port
module dmem_port_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h10010000,
    parameter int          MEM_BYTES  = 1024,
    parameter int          CPU_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sext,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic        dm_ena,
    output logic        dm_wena,
    output logic        dm_rena,
    output logic [3:0]  dm_wflag,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam int SW = $clog2(CPU_STREAK + 1);

    logic [SW-1:0] streak;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic          sel_sext;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [31:0]   off;
    logic          bad;
    logic          ok;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ld_data;

    // Grants are withheld during reset so nothing reaches the memory or the done path.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            cpu_gnt = cpu_req && !(dbg_req && streak == SW'(CPU_STREAK));
            dbg_gnt = dbg_req && !cpu_gnt;
        end
    end

    always_comb begin
        sel_we    = cpu_we;
        sel_size  = cpu_size;
        sel_sext  = cpu_sext;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (dbg_gnt) begin
            sel_we    = dbg_we;
            sel_size  = 2'b10;
            sel_sext  = 1'b0;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
        off = sel_addr - BASE_ADDR;
        bad = (off >= 32'(MEM_BYTES)) || (sel_size == 2'b11) ||
              (sel_size == 2'b01 && sel_addr[0]) ||
              (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
        ok  = (cpu_gnt || dbg_gnt) && !bad;
    end

    always_comb begin
        dm_ena   = 1'b0;
        dm_wena  = 1'b0;
        dm_rena  = 1'b0;
        dm_wflag = 4'b0000;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        if (ok) begin
            dm_ena  = 1'b1;
            dm_addr = {sel_addr[31:2], 2'b00};
            if (sel_we) begin
                dm_wena = 1'b1;
                case (sel_size)
                    2'b00: begin
                        dm_wflag = 4'b0001 << sel_addr[1:0];
                        dm_wdata = {4{sel_wdata[7:0]}};
                    end
                    2'b01: begin
                        dm_wflag = 4'b0011 << sel_addr[1:0];
                        dm_wdata = {2{sel_wdata[15:0]}};
                    end
                    default: begin
                        dm_wflag = 4'b1111;
                        dm_wdata = sel_wdata;
                    end
                endcase
            end else begin
                dm_rena = 1'b1;
            end
        end
    end

    always_comb begin
        case (sel_addr[1:0])
            2'd0:    rbyte = dm_rdata[7:0];
            2'd1:    rbyte = dm_rdata[15:8];
            2'd2:    rbyte = dm_rdata[23:16];
            default: rbyte = dm_rdata[31:24];
        endcase
        rhalf = sel_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (sel_size)
            2'b00:   ld_data = sel_sext ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            2'b01:   ld_data = sel_sext ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            default: ld_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak    <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'h0;
            dbg_done  <= 1'b0;
            dbg_err   <= 1'b0;
            dbg_rdata <= 32'h0;
        end else begin
            cpu_done <= cpu_gnt;
            cpu_err  <= cpu_gnt && bad;
            dbg_done <= dbg_gnt;
            dbg_err  <= dbg_gnt && bad;
            if (cpu_gnt)
                cpu_rdata <= (ok && !sel_we) ? ld_data : 32'h0;
            if (dbg_gnt)
                dbg_rdata <= (ok && !sel_we) ? dm_rdata : 32'h0;
            // Streak counts CPU wins only while the debug port is actually waiting.
            if (dbg_gnt || !dbg_req)
                streak <= '0;
            else if (cpu_gnt && streak != SW'(CPU_STREAK))
                streak <= streak + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - randomized self-checking bench for dmem_port_ctrl
module tb_dmem_port_ctrl;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int MEMB = 1024;
    localparam int STREAK = 4;

    logic clk = 1'b0;
    logic rst;
    logic cpu_req, cpu_we, cpu_sext;
    logic [1:0] cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic cpu_gnt, cpu_done, cpu_err;
    logic dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic dbg_gnt, dbg_done, dbg_err;
    logic dm_ena, dm_wena, dm_rena;
    logic [3:0] dm_wflag;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    always #5 clk = ~clk;

    dmem_port_ctrl #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .CPU_STREAK(STREAK)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .dm_ena(dm_ena), .dm_wena(dm_wena), .dm_rena(dm_rena), .dm_wflag(dm_wflag),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    // Byte-lane data memory attached to the port
    logic [7:0] mem [MEMB];
    logic [7:0] ref_mem [MEMB];

    always_comb begin
        logic [31:0] idx;
        idx = dm_addr - BASE;
        dm_rdata = 32'h0;
        if (idx <= 32'(MEMB - 4))
            dm_rdata = {mem[idx + 3], mem[idx + 2], mem[idx + 1], mem[idx]};
    end

    always @(posedge clk) begin
        if (dm_wena)
            for (int i = 0; i < 4; i++)
                if (dm_wflag[i]) mem[dm_addr - BASE + 32'(i)] <= dm_wdata[8*i +: 8];
    end

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    // Pending requests as seen by each requester
    logic cpu_pend = 1'b0, c_we, c_sext;
    logic [1:0] c_size;
    logic [31:0] c_addr, c_wdata;
    logic dbg_pend = 1'b0, d_we;
    logic [31:0] d_addr, d_wdata;
    int run = 0;
    logic last_dbg;

    task automatic run_cycle();
        logic ec, ed, we, sx, bad;
        logic [1:0] sz;
        logic [31:0] a, wd, off, v, exp_wd;
        int nb;
        cpu_req = cpu_pend; cpu_we = c_we; cpu_size = c_size; cpu_sext = c_sext;
        cpu_addr = c_addr; cpu_wdata = c_wdata;
        dbg_req = dbg_pend; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wdata;
        @(negedge clk);
        ec = cpu_pend && !(dbg_pend && run == STREAK);
        ed = dbg_pend && !ec;
        chk("cpu_gnt", cpu_gnt, ec);
        chk("dbg_gnt", dbg_gnt, ed);
        last_dbg = ed;
        bad = 1'b0;
        v = 32'h0;
        if (ec || ed) begin
            if (ed) begin we = d_we; sz = 2'd2; sx = 1'b0; a = d_addr; wd = d_wdata; end
            else begin we = c_we; sz = c_size; sx = c_sext; a = c_addr; wd = c_wdata; end
            off = a - BASE;
            bad = off >= MEMB || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
            if (bad) begin
                chk("err_dm_ena", dm_ena, 0);
                chk("err_dm_wena", dm_wena, 0);
                chk("err_dm_rena", dm_rena, 0);
            end else begin
                nb = 1 << sz;
                chk("dm_ena", dm_ena, 1);
                chk("dm_addr", dm_addr, a - a % 4);
                if (we) begin
                    chk("dm_wena", dm_wena, 1);
                    chk("dm_rena_st", dm_rena, 0);
                    chk("dm_wflag", dm_wflag, ((1 << nb) - 1) << (a % 4));
                    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
                    chk("dm_wdata", dm_wdata, exp_wd);
                    for (int i = 0; i < nb; i++) ref_mem[off + 32'(i)] = wd[8*i +: 8];
                end else begin
                    chk("dm_rena", dm_rena, 1);
                    chk("dm_wena_ld", dm_wena, 0);
                    chk("dm_wflag_ld", dm_wflag, 0);
                    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[off + 32'(i)]) << (8 * i));
                    if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
                end
            end
        end else begin
            chk("idle_dm_ena", dm_ena, 0);
            chk("idle_dm_wena", dm_wena, 0);
        end
        if (ed || !dbg_pend) run = 0;
        else if (ec && run < STREAK) run++;
        @(posedge clk); #1;
        chk("cpu_done", cpu_done, ec);
        chk("dbg_done", dbg_done, ed);
        if (ec) begin
            chk("cpu_err", cpu_err, bad);
            chk("cpu_rdata", cpu_rdata, v);
            cpu_pend = 1'b0;
        end
        if (ed) begin
            chk("dbg_err", dbg_err, bad);
            chk("dbg_rdata", dbg_rdata, v);
            dbg_pend = 1'b0;
        end
    endtask

    task automatic issue_cpu(input logic we, input logic [1:0] sz, input logic sx,
                             input logic [31:0] a, input logic [31:0] wd);
        cpu_pend = 1'b1; c_we = we; c_size = sz; c_sext = sx; c_addr = a; c_wdata = wd;
        for (int i = 0; i < 20 && cpu_pend; i++) run_cycle();
        if (cpu_pend) begin chk("cpu_timeout", 1, 0); cpu_pend = 1'b0; end
    endtask

    task automatic issue_dbg(input logic we, input logic [31:0] a, input logic [31:0] wd);
        dbg_pend = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 20 && dbg_pend; i++) run_cycle();
        if (dbg_pend) begin chk("dbg_timeout", 1, 0); dbg_pend = 1'b0; end
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz);
        logic [31:0] off;
        if ($urandom_range(0, 15) == 0)
            off = $urandom_range(0, 1) ? 32'(MEMB) + $urandom_range(0, 64) : -$urandom_range(1, 16);
        else
            off = $urandom_range(0, MEMB - 1);
        if ($urandom_range(0, 3) != 0)
            off = (sz == 2'd1) ? off & ~32'd1 : (sz == 2'd0) ? off : off & ~32'd3;
        return BASE + off;
    endfunction

    initial begin
        logic [9:0] seq;
        logic [31:0] old;
        for (int i = 0; i < MEMB; i++) begin ref_mem[i] = 8'($urandom); mem[i] = ref_mem[i]; end
        c_we = 0; c_size = 0; c_sext = 0; c_addr = 0; c_wdata = 0;
        d_we = 0; d_addr = 0; d_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_sext = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_cpu_err", cpu_err, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_done", dbg_done, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_dm_ena", dm_ena, 0);
        chk("rst_dm_wflag", dm_wflag, 0);
        rst = 1'b0;

        issue_cpu(1, 2, 0, 32'h10010008, 32'hA1B2C3D4);
        issue_cpu(0, 2, 0, 32'h10010008, 0);
        chk("t1_lw", cpu_rdata, 32'hA1B2C3D4);
        issue_cpu(1, 0, 0, 32'h10010009, 32'h00000080);
        issue_cpu(0, 0, 1, 32'h10010009, 0);
        chk("t2_lb", cpu_rdata, 32'hFFFFFF80);
        issue_cpu(0, 0, 0, 32'h10010009, 0);
        chk("t2_lbu", cpu_rdata, 32'h00000080);
        issue_cpu(1, 1, 0, 32'h1001000A, 32'h00008001);
        issue_cpu(0, 1, 1, 32'h1001000A, 0);
        chk("t3_lh", cpu_rdata, 32'hFFFF8001);
        issue_cpu(0, 1, 0, 32'h1001000B, 0);
        chk("t3_lhu_err", cpu_err, 1);

        seq = '0;
        for (int n = 0; n < 10; n++) begin
            if (!cpu_pend) begin cpu_pend = 1; c_we = 0; c_size = 2; c_sext = 0; c_addr = BASE + 32'(4 * n); end
            if (!dbg_pend) begin dbg_pend = 1; d_we = 0; d_addr = BASE + 32'h100; end
            run_cycle();
            seq[n] = last_dbg;
        end
        chk("t4_arb_seq", 32'(seq), 32'b1000010000);
        for (int i = 0; i < 4 && (cpu_pend || dbg_pend); i++) run_cycle();

        issue_cpu(0, 2, 0, 32'h10010400, 0);
        chk("t5_lw_err", cpu_err, 1);
        issue_dbg(1, 32'h1000FFFC, 32'h12345678);
        chk("t5_dbg_err", dbg_err, 1);

        old = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
        cpu_req = 1; cpu_we = 1; cpu_size = 2; cpu_addr = 32'h10010010; cpu_wdata = ~old;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_wena", dm_wena, 0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 0; cpu_we = 0; run = 0;
        chk("t6_no_done", cpu_done, 0);
        @(negedge clk);
        chk("t6_gnt", cpu_gnt, 0);
        chk("t6_dm_ena", dm_ena, 0);
        chk("t6_err", cpu_err, 0);
        chk("t6_rdata", cpu_rdata, 0);
        @(posedge clk); #1;
        issue_cpu(0, 2, 0, 32'h10010010, 0);
        chk("t6_mem_kept", cpu_rdata, old);

        for (int n = 0; n < 400; n++) begin
            if (!cpu_pend && $urandom_range(0, 3) != 0) begin
                cpu_pend = 1; c_we = 1'($urandom); c_sext = 1'($urandom);
                c_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                c_addr = rand_addr(c_size); c_wdata = $urandom;
            end
            if (!dbg_pend && $urandom_range(0, 2) == 0) begin
                dbg_pend = 1; d_we = 1'($urandom); d_addr = rand_addr(2'd2); d_wdata = $urandom;
            end
            run_cycle();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
